uart_frame_bridge: RTL and testbench
====================================

Name: uart_frame_bridge

Overview:
Framing stage between the UART byte receiver/transmitter pair and the challenge core. Collects NUM_BYTES received bytes into one block and hands it to the core with a valid/ready handshake. Accepts the core's result block and serializes it back out through the UART transmitter one byte at a time. It sits directly downstream of UART_RX and directly upstream of UART_TX.

Parameters:
NUM_BYTES, 8, bytes per block, at least 2; the data width is NUM_BYTES*8.
TIMEOUT_CLKS, 104*20, number of idle clocks after which a partial RX frame is discarded.
TX_GAP_CLKS, 2, number of clocks between i_TX_Done and the next o_TX_DV; must be at least 2 for the UART_TX cleanup state.

Ports:
i_Clock  in  1  system clock
i_Reset_n  in  1  reset; synchronous, active-low
i_RX_DV  in  1  one-cycle strobe from UART_RX
i_RX_Byte  in  8  received byte, valid while i_RX_DV is high
o_Block_Valid  out  1  assembled block available
o_Block_Data  out  NUM_BYTES*8  assembled block
i_Block_Ready  in  1  core accepts the block
i_Result_Valid  in  1  core result available
i_Result_Data  in  NUM_BYTES*8  core result
o_Result_Ready  out  1  bridge accepts the result
o_TX_DV  out  1  one-cycle strobe to UART_TX
o_TX_Byte  out  8  byte to transmit
i_TX_Done  in  1  one-cycle strobe from UART_TX
o_Drop  out  1  one-cycle pulse when a byte is discarded or a partial frame times out

Behaviour:
- Reset (i_Reset_n low at a rising edge) forces:
  - state COLLECT, byte count 0, timeout counter 0;
  - all outputs 0, including o_Block_Data and o_TX_Byte.
- Reset mid-operation aborts any frame or transmission immediately; there is no partial flush.
- Byte order is big-endian on both paths: the first byte received lands in bits [N*8-1:N*8-8], and the first byte sent comes from the same bits.
- States:
  - COLLECT:
    - On i_RX_DV, shift the byte in and increment the count.
    - When the count reaches NUM_BYTES, go to PRESENT on the next cycle with o_Block_Valid=1. Count wraps to 0.
    - While count>0, the timeout counter increments each cycle and clears on i_RX_DV.
    - If the timeout counter reaches TIMEOUT_CLKS: count=0, pulse o_Drop, stay in COLLECT. The block register contents are don't-care.
  - PRESENT:
    - o_Block_Valid is held high and o_Block_Data is held stable until i_Block_Ready.
    - The handshake completes in the cycle where both are high; the next state is WAIT_RES with o_Block_Valid=0.
  - WAIT_RES:
    - o_Result_Ready=1.
    - On i_Result_Valid && o_Result_Ready, latch i_Result_Data into the shift register, set byte index to 0, go to TX_SEND.
  - TX_SEND:
    - Assert o_TX_DV for exactly one cycle with o_TX_Byte = current MSB byte, then go to TX_WAIT.
  - TX_WAIT:
    - Wait for i_TX_Done, then shift left 8 and increment the index.
    - If index==NUM_BYTES-1 at i_TX_Done, return to COLLECT.
    - Otherwise go to TX_GAP.
  - TX_GAP:
    - Count TX_GAP_CLKS cycles, then go to TX_SEND.
- i_RX_DV in any state other than COLLECT drops the byte and pulses o_Drop for one cycle; the state is unaffected.
- i_RX_DV on the same cycle that COLLECT is entered from TX is accepted.
- The block-out latency is 1 clock: o_Block_Valid rises the cycle after the final i_RX_DV.
- Exactly one o_TX_DV is issued per byte; no o_TX_DV is issued before the i_TX_Done of the previous byte.
- o_Result_Ready is low in every state except WAIT_RES.

Decomposition:
- Shared package (uart_pkg): state encoding constants (COLLECT, PRESENT, WAIT_RES, TX_SEND, TX_WAIT, TX_GAP) and the UART defaults:
  - CLKS_PER_BIT=104;
  - BYTE_W=8.
- One natural sub-module: frame_timeout_counter, a clear/enable/terminal-count counter used for both TIMEOUT_CLKS and TX_GAP_CLKS.
- The rest of the logic stays in a single FSM.

Test Plan:
- Send bytes 01 02 03 04 05 06 07 08 through UART_RX, with i_Block_Ready tied high -> o_Block_Data=64'h0102030405060708, and o_Block_Valid is high for exactly 1 cycle.
- Hold i_Block_Ready low for 50 clocks after the block -> o_Block_Valid and o_Block_Data remain stable for 50 clocks; one extra byte sent meanwhile produces one o_Drop pulse, and the held block is unchanged.
- Send 3 bytes, idle for TIMEOUT_CLKS+5 clocks, then send 8 bytes A0..A7 -> one o_Drop pulse, then o_Block_Data=64'hA0A1A2A3A4A5A6A7.
- Result 64'hDEADBEEFCAFEF00D via UART_TX loopback into the TB UART_RX -> the RX sees DE AD BE EF CA FE F0 0D in order, with exactly 8 o_TX_DV pulses, each at least TX_GAP_CLKS after the previous i_TX_Done.
- Assert i_Reset_n low for 1 clock during the fourth TX byte -> all outputs are 0 the next cycle, no further o_TX_DV, and a fresh 8-byte frame is then assembled correctly.
- i_Result_Valid held high in COLLECT -> o_Result_Ready stays 0 and no transmission starts until a block has been presented and accepted.

Source files
------------

// File: rtl/uart_pkg.sv
// Purpose : shared UART constants and the frame bridge state encoding.
// Latency : n/a (declarations only).
// Backpres: n/a.
package uart_pkg;

   localparam int CLKS_PER_BIT = 104;
   localparam int BYTE_W       = 8;

   typedef enum logic [2:0] {
      COLLECT  = 3'd0,
      PRESENT  = 3'd1,
      WAIT_RES = 3'd2,
      TX_SEND  = 3'd3,
      TX_WAIT  = 3'd4,
      TX_GAP   = 3'd5
   } state_t;

endpackage

// File: rtl/uart_frame_bridge_if.sv
// Purpose : bundles the UART-side strobes and the core-side block/result handshakes.
// Latency : n/a (wiring only).
// Backpres: valid/ready on block and result paths; strobe-only on UART RX/TX.
// Modports: slave = the bridge itself, master = whoever drives the bridge inputs.
interface uart_frame_bridge_if
   import uart_pkg::*;
#(
   parameter int NUM_BYTES = 8
);
   logic                          i_RX_DV;
   logic [BYTE_W-1:0]             i_RX_Byte;
   logic                          o_Block_Valid;
   logic [NUM_BYTES*BYTE_W-1:0]   o_Block_Data;
   logic                          i_Block_Ready;
   logic                          i_Result_Valid;
   logic [NUM_BYTES*BYTE_W-1:0]   i_Result_Data;
   logic                          o_Result_Ready;
   logic                          o_TX_DV;
   logic [BYTE_W-1:0]             o_TX_Byte;
   logic                          i_TX_Done;
   logic                          o_Drop;

   modport slave (
      input  i_RX_DV, i_RX_Byte, i_Block_Ready, i_Result_Valid, i_Result_Data, i_TX_Done,
      output o_Block_Valid, o_Block_Data, o_Result_Ready, o_TX_DV, o_TX_Byte, o_Drop
   );

   modport master (
      output i_RX_DV, i_RX_Byte, i_Block_Ready, i_Result_Valid, i_Result_Data, i_TX_Done,
      input  o_Block_Valid, o_Block_Data, o_Result_Ready, o_TX_DV, o_TX_Byte, o_Drop
   );

endinterface

// File: rtl/frame_timeout_counter.sv
// Purpose : clear/enable up-counter flagging the cycle its count would reach TERMINAL.
// Latency : o_Terminal is combinational from the count; count updates on the next edge.
// Backpres: none; the owner decides when to clear.
// Ports   : i_Clock, i_Reset_n (sync active-low), i_Clear, i_Enable -> o_Terminal.
module frame_timeout_counter #(
   parameter int TERMINAL = 2
) (
   input  logic i_Clock,
   input  logic i_Reset_n,
   input  logic i_Clear,
   input  logic i_Enable,
   output logic o_Terminal
);

   localparam int W = $clog2(TERMINAL + 1);

   logic [W-1:0] cnt;

   always_ff @(posedge i_Clock) begin
      if (!i_Reset_n) begin
         cnt <= '0;
      end else if (i_Clear) begin
         cnt <= '0;
      end else if (i_Enable) begin
         cnt <= cnt + W'(1);
      end
   end

   // Fires on the enabled cycle that completes TERMINAL counted cycles.
   assign o_Terminal = i_Enable && (cnt == W'(TERMINAL - 1));

endmodule

// File: rtl/uart_frame_bridge.sv
// Purpose : packs NUM_BYTES UART bytes into a block for the core, serializes the result back out.
// Latency : block valid 1 clk after the last RX byte; first TX strobe 2 clks after result accept.
// Backpres: block held until i_Block_Ready; RX bytes outside COLLECT are dropped with o_Drop.
// Ports   : i_Clock, i_Reset_n (sync active-low), bus (uart_frame_bridge_if.slave).
module uart_frame_bridge
   import uart_pkg::*;
#(
   parameter int NUM_BYTES    = 8,
   parameter int TIMEOUT_CLKS = CLKS_PER_BIT * 20,
   parameter int TX_GAP_CLKS  = 2
) (
   input  logic                  i_Clock,
   input  logic                  i_Reset_n,
   uart_frame_bridge_if.slave    bus
);

   localparam int DW = NUM_BYTES * BYTE_W;
   localparam int CW = $clog2(NUM_BYTES);
   localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);

   state_t          state;
   logic [CW-1:0]   rx_count;
   logic [CW-1:0]   tx_idx;
   logic [DW-1:0]   tx_shift;

   logic            to_en;
   logic            to_tc;
   logic            gap_en;
   logic            gap_tc;
   logic            last_tx_done;
   logic            drop_now;

   // Idle timer only runs while a partial frame is pending and no byte arrives.
   assign to_en  = (state == COLLECT) && (rx_count != '0) && !bus.i_RX_DV;
   assign gap_en = (state == TX_GAP);

   // The final TX_DONE hands control back to COLLECT in the same cycle, so a
   // byte arriving right then is taken rather than dropped.
   assign last_tx_done = (state == TX_WAIT) && bus.i_TX_Done && (tx_idx == LAST);

   assign drop_now = (bus.i_RX_DV && (state != COLLECT) && !last_tx_done) || to_tc;

   frame_timeout_counter #(.TERMINAL(TIMEOUT_CLKS)) u_rx_timeout (
      .i_Clock    (i_Clock),
      .i_Reset_n  (i_Reset_n),
      .i_Clear    (!to_en),
      .i_Enable   (to_en),
      .o_Terminal (to_tc)
   );

   frame_timeout_counter #(.TERMINAL(TX_GAP_CLKS)) u_tx_gap (
      .i_Clock    (i_Clock),
      .i_Reset_n  (i_Reset_n),
      .i_Clear    (!gap_en),
      .i_Enable   (gap_en),
      .o_Terminal (gap_tc)
   );

   always_ff @(posedge i_Clock) begin
      if (!i_Reset_n) begin
         state              <= COLLECT;
         rx_count           <= '0;
         tx_idx             <= '0;
         tx_shift           <= '0;
         bus.o_Block_Valid  <= 1'b0;
         bus.o_Block_Data   <= '0;
         bus.o_Result_Ready <= 1'b0;
         bus.o_TX_DV        <= 1'b0;
         bus.o_TX_Byte      <= '0;
         bus.o_Drop         <= 1'b0;
      end else begin
         bus.o_TX_DV <= 1'b0;
         bus.o_Drop  <= drop_now;

         case (state)
            COLLECT: begin
               if (bus.i_RX_DV) begin
                  // Shift left so the first byte ends up in the MSB lane.
                  bus.o_Block_Data <= {bus.o_Block_Data[DW-BYTE_W-1:0], bus.i_RX_Byte};
                  if (rx_count == LAST) begin
                     rx_count          <= '0;
                     bus.o_Block_Valid <= 1'b1;
                     state             <= PRESENT;
                  end else begin
                     rx_count <= rx_count + CW'(1);
                  end
               end else if (to_tc) begin
                  rx_count <= '0;
               end
            end

            PRESENT: begin
               if (bus.i_Block_Ready) begin
                  bus.o_Block_Valid  <= 1'b0;
                  bus.o_Result_Ready <= 1'b1;
                  state              <= WAIT_RES;
               end
            end

            WAIT_RES: begin
               if (bus.i_Result_Valid) begin
                  tx_shift           <= bus.i_Result_Data;
                  tx_idx             <= '0;
                  bus.o_Result_Ready <= 1'b0;
                  state              <= TX_SEND;
               end
            end

            TX_SEND: begin
               bus.o_TX_DV   <= 1'b1;
               bus.o_TX_Byte <= tx_shift[DW-1 -: BYTE_W];
               state         <= TX_WAIT;
            end

            TX_WAIT: begin
               if (bus.i_TX_Done) begin
                  tx_shift <= tx_shift << BYTE_W;
                  if (tx_idx == LAST) begin
                     tx_idx <= '0;
                     state  <= COLLECT;
                     if (bus.i_RX_DV) begin
                        bus.o_Block_Data <= {bus.o_Block_Data[DW-BYTE_W-1:0], bus.i_RX_Byte};
                        rx_count         <= CW'(1);
                     end
                  end else begin
                     tx_idx <= tx_idx + CW'(1);
                     state  <= TX_GAP;
                  end
               end
            end

            TX_GAP: begin
               if (gap_tc) begin
                  state <= TX_SEND;
               end
            end

            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_frame_bridge.sv
// Purpose : self-checking bench for uart_frame_bridge with a byte-level reference model.
// Latency : n/a.
// Backpres: n/a.
module tb_uart_frame_bridge;
   import uart_pkg::*;

   localparam int NB  = 8;
   localparam int DW  = NB * 8;
   localparam int TO  = CLKS_PER_BIT * 20;
   localparam int GAP = 2;

   logic r_clk   = 1'b0;
   logic r_rst_n = 1'b0;
   always #5 r_clk = ~r_clk;

   uart_frame_bridge_if #(.NUM_BYTES(NB)) bus();

   uart_frame_bridge #(
      .NUM_BYTES    (NB),
      .TIMEOUT_CLKS (TO),
      .TX_GAP_CLKS  (GAP)
   ) dut (
      .i_Clock   (r_clk),
      .i_Reset_n (r_rst_n),
      .bus       (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Observation state gathered on the falling edge.
   int              cyc        = 0;
   int              drop_cnt   = 0;
   int              bv_cycles  = 0;
   int              gap_viol   = 0;
   int              last_done  = -1000;
   bit              outstanding = 1'b0;
   logic [DW-1:0]   blk_q[$];
   logic [7:0]      tx_q[$];
   int              blk_rd = 0;
   int              tx_rd  = 0;

   always @(posedge r_clk) cyc <= cyc + 1;

   always @(negedge r_clk) begin
      if (r_rst_n) begin
         if (bus.o_Drop) drop_cnt++;
         if (bus.o_Block_Valid) begin
            bv_cycles++;
            if (bus.i_Block_Ready) blk_q.push_back(bus.o_Block_Data);
         end
         if (bus.o_TX_DV) begin
            if (outstanding || (cyc - last_done) < GAP) gap_viol++;
            outstanding = 1'b1;
            tx_q.push_back(bus.o_TX_Byte);
         end
         if (bus.i_TX_Done) begin
            outstanding = 1'b0;
            last_done   = cyc;
         end
      end else begin
         outstanding = 1'b0;
      end
   end

   // UART_TX stand-in: answers every strobe with a done pulse a few clocks later.
   initial begin
      bus.i_TX_Done = 1'b0;
      forever begin
         @(negedge r_clk);
         if (bus.o_TX_DV) begin
            repeat ($urandom_range(3, 8)) @(posedge r_clk);
            #1 bus.i_TX_Done = 1'b1;
            @(posedge r_clk);
            #1 bus.i_TX_Done = 1'b0;
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: time %0t exceeded, required finish before 3000000", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge r_clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int idle);
      bus.i_RX_DV   = 1'b1;
      bus.i_RX_Byte = b;
      tick();
      bus.i_RX_DV   = 1'b0;
      repeat (idle) tick();
   endtask

   // Reference: block is the bytes concatenated, first byte most significant.
   function automatic logic [DW-1:0] pack(input logic [7:0] b[NB]);
      logic [DW-1:0] v = '0;
      for (int i = 0; i < NB; i++) v = (v << 8) | DW'(b[i]);
      return v;
   endfunction

   task automatic send_block(input logic [7:0] b[NB]);
      for (int i = 0; i < NB; i++) send_byte(b[i], $urandom_range(0, 3));
   endtask

   task automatic wait_block(input string tag, input logic [DW-1:0] exp);
      int t = 0;
      while (blk_q.size() <= blk_rd && t < 200) begin
         tick();
         t++;
      end
      tick();
      chk({tag, "_cnt"}, DW'(blk_q.size() - blk_rd), DW'(1));
      if (blk_q.size() > blk_rd) begin
         chk({tag, "_data"}, blk_q[blk_rd], exp);
         blk_rd = blk_q.size();
      end
   endtask

   task automatic do_result(input logic [DW-1:0] r);
      int t = 0;
      bus.i_Result_Valid = 1'b1;
      bus.i_Result_Data  = r;
      while (t < 200) begin
         @(negedge r_clk);
         if (bus.o_Result_Ready) break;
         t++;
      end
      @(posedge r_clk);
      #1;
      bus.i_Result_Valid = 1'b0;
      chk("res_ready_seen", DW'(t < 200), DW'(1));
   endtask

   // Reference: byte i on the wire is bits [DW-1-8i -: 8] of the result.
   task automatic check_tx(input string tag, input logic [DW-1:0] r);
      int t    = 0;
      int base = tx_rd;
      while (tx_q.size() < base + NB && t < 1000) begin
         tick();
         t++;
      end
      repeat (30) tick();
      chk({tag, "_ntx"}, DW'(tx_q.size() - base), DW'(NB));
      for (int i = 0; i < NB; i++) begin
         if (base + i < tx_q.size())
            chk($sformatf("%s_b%0d", tag, i), DW'(tx_q[base + i]),
                DW'((r >> (8 * (NB - 1 - i))) & DW'(8'hFF)));
      end
      tx_rd = tx_q.size();
      chk({tag, "_gap"}, DW'(gap_viol), DW'(0));
   endtask

   initial begin
      logic [7:0]    b[NB];
      logic [DW-1:0] exp_blk;
      logic [DW-1:0] res;
      int            d0;
      int            bv0;
      int            unstable;
      int            rr_seen;
      int            base;
      int            t;

      bus.i_RX_DV        = 1'b0;
      bus.i_RX_Byte      = '0;
      bus.i_Block_Ready  = 1'b0;
      bus.i_Result_Valid = 1'b0;
      bus.i_Result_Data  = '0;

      // Reset state.
      repeat (3) tick();
      @(negedge r_clk);
      chk("rst_block_data", bus.o_Block_Data, DW'(0));
      chk("rst_ctl", DW'({bus.o_Block_Valid, bus.o_Result_Ready, bus.o_TX_DV,
                          bus.o_Drop, bus.o_TX_Byte}), DW'(0));
      tick();
      r_rst_n = 1'b1;
      tick();

      // 01..08 with ready tied high, then result DEADBEEFCAFEF00D out.
      bus.i_Block_Ready = 1'b1;
      for (int i = 0; i < NB; i++) b[i] = 8'(i + 1);
      bv0 = bv_cycles;
      send_block(b);
      wait_block("seq_block", pack(b));
      chk("seq_valid_cycles", DW'(bv_cycles - bv0), DW'(1));
      do_result(64'hDEADBEEFCAFEF00D);
      check_tx("deadbeef", 64'hDEADBEEFCAFEF00D);

      // Held block with ready low for 50 clocks; one stray byte in the middle.
      bus.i_Block_Ready = 1'b0;
      for (int i = 0; i < NB; i++) b[i] = 8'($urandom);
      exp_blk = pack(b);
      send_block(b);
      d0 = drop_cnt;
      unstable = 0;
      for (int i = 0; i < 50; i++) begin
         bus.i_RX_DV   = (i == 20);
         bus.i_RX_Byte = 8'($urandom);
         @(negedge r_clk);
         if (!bus.o_Block_Valid || bus.o_Block_Data !== exp_blk) unstable++;
         tick();
      end
      bus.i_RX_DV = 1'b0;
      chk("hold_unstable", DW'(unstable), DW'(0));
      chk("hold_drop", DW'(drop_cnt - d0), DW'(1));
      bus.i_Block_Ready = 1'b1;
      wait_block("hold_block", exp_blk);
      res = DW'({$urandom, $urandom});
      do_result(res);
      check_tx("hold_tx", res);

      // Partial frame timeout, then a clean A0..A7 frame.
      d0 = drop_cnt;
      for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1);
      repeat (TO + 5) tick();
      chk("to_drop", DW'(drop_cnt - d0), DW'(1));
      chk("to_no_block", DW'(blk_q.size() - blk_rd), DW'(0));
      for (int i = 0; i < NB; i++) b[i] = 8'hA0 + 8'(i);
      send_block(b);
      wait_block("to_block", 64'hA0A1A2A3A4A5A6A7);
      res = DW'({$urandom, $urandom});
      do_result(res);
      check_tx("to_tx", res);

      // Reset pulse during the fourth TX byte.
      for (int i = 0; i < NB; i++) b[i] = 8'($urandom);
      send_block(b);
      wait_block("pre_rst_block", pack(b));
      base = tx_rd;
      do_result(DW'({$urandom, $urandom}));
      t = 0;
      while (tx_q.size() < base + 4 && t < 500) begin
         tick();
         t++;
      end
      chk("rst_reach_b4", DW'(tx_q.size() - base), DW'(4));
      r_rst_n = 1'b0;
      tick();
      r_rst_n = 1'b1;
      @(negedge r_clk);
      chk("mid_rst_data", bus.o_Block_Data, DW'(0));
      chk("mid_rst_ctl", DW'({bus.o_Block_Valid, bus.o_Result_Ready, bus.o_TX_DV,
                              bus.o_Drop, bus.o_TX_Byte}), DW'(0));
      repeat (40) tick();
      chk("mid_rst_no_tx", DW'(tx_q.size() - base), DW'(4));
      tx_rd = tx_q.size();
      for (int i = 0; i < NB; i++) b[i] = 8'($urandom);
      send_block(b);
      wait_block("post_rst_block", pack(b));
      res = DW'({$urandom, $urandom});
      do_result(res);
      check_tx("post_rst_tx", res);

      // Result offered early must wait for a presented and accepted block.
      res = DW'({$urandom, $urandom});
      bus.i_Result_Valid = 1'b1;
      bus.i_Result_Data  = res;
      rr_seen = 0;
      base    = tx_q.size();
      for (int i = 0; i < 30; i++) begin
         @(negedge r_clk);
         if (bus.o_Result_Ready) rr_seen++;
         tick();
      end
      chk("early_res_ready", DW'(rr_seen), DW'(0));
      chk("early_res_no_tx", DW'(tx_q.size() - base), DW'(0));
      for (int i = 0; i < NB; i++) b[i] = 8'($urandom);
      send_block(b);
      wait_block("early_block", pack(b));
      check_tx("early_tx", res);
      bus.i_Result_Valid = 1'b0;

      // Random frames with a random accept delay.
      for (int k = 0; k < 3; k++) begin
         bus.i_Block_Ready = 1'b0;
         for (int i = 0; i < NB; i++) b[i] = 8'($urandom);
         send_block(b);
         repeat ($urandom_range(0, 10)) tick();
         bus.i_Block_Ready = 1'b1;
         wait_block($sformatf("rnd%0d_block", k), pack(b));
         res = DW'({$urandom, $urandom});
         do_result(res);
         check_tx($sformatf("rnd%0d_tx", k), res);
      end

      repeat (5) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
